// File: rtl/ls_iline_fill.sv
// Instruction-line fill from local store: LINE_QW quadword reads through a granted fixed-latency port, assembled big-endian.
// Line valid LINE_QW+LS_LAT+1 cycles after accept with continuous grant; missing grants insert bubbles, line held until ack.
module ls_iline_fill #(
  parameter int LINE_QW    = 4,
  parameter int LS_QADDR_W = 14,
  parameter int LS_LAT     = 2,
  parameter int PC_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [PC_W-1:0]         req_pc,
  output logic                    req_ready,
  input  logic                    flush,
  input  logic                    ls_grant,
  output logic                    ls_rd_en,
  output logic [LS_QADDR_W-1:0]   ls_rd_addr,
  input  logic [127:0]            ls_rd_data,
  output logic                    line_valid,
  output logic [PC_W-1:0]         line_base,
  output logic [LINE_QW*128-1:0]  line_data,
  input  logic                    line_ack
);

  localparam int CNT_W = $clog2(LINE_QW) + 1;
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(LINE_QW - 1);
  localparam logic [LS_LAT-1:0]     VSR_TAIL = LS_LAT'(1) << (LS_LAT - 1);
  localparam logic [LS_QADDR_W-1:0] LINE_MASK = ~LS_QADDR_W'(LINE_QW - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ABORT} state_t;

  state_t                  r_state;
  logic [LS_QADDR_W-1:0]   r_base_q;
  logic [CNT_W-1:0]        r_issue_cnt;
  logic [CNT_W-1:0]        r_ret_cnt;
  logic [LS_LAT-1:0]       r_vsr;
  logic                    r_line_valid;
  logic [PC_W-1:0]         r_line_base;
  logic [LINE_QW*128-1:0]  r_line_data;

  logic                    w_issue;
  logic                    w_ret;
  logic [LS_QADDR_W-1:0]   w_req_q;
  logic                    w_unused;

  // Word-offset bits of the PC select an instruction within a quadword, irrelevant to the fill.
  assign w_unused = ^req_pc[1:0];
  assign w_req_q  = req_pc[PC_W-1:2] & LINE_MASK;

  // A flush suppresses the issue in its own cycle so nothing new enters the pipe once an abort is requested.
  assign w_issue = (r_state == S_ISSUE) && ls_grant && !flush && !reset;
  assign w_ret   = r_vsr[LS_LAT-1] && ((r_state == S_ISSUE) || (r_state == S_WAIT)) && !flush;

  assign req_ready  = (r_state == S_IDLE) && !flush && !reset;
  assign ls_rd_en   = w_issue;
  assign ls_rd_addr = r_base_q + LS_QADDR_W'(r_issue_cnt);
  assign line_valid = r_line_valid;
  assign line_base  = r_line_base;
  assign line_data  = r_line_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_base_q     <= '0;
      r_issue_cnt  <= '0;
      r_ret_cnt    <= '0;
      r_vsr        <= '0;
      r_line_valid <= 1'b0;
      r_line_base  <= '0;
      r_line_data  <= '0;
    end else begin
      r_vsr <= (r_vsr << 1) | LS_LAT'(w_issue);

      if (w_ret) begin
        for (int q = 0; q < LINE_QW; q++) begin
          if (r_ret_cnt == CNT_W'(q)) r_line_data[(LINE_QW-q)*128-1 -: 128] <= ls_rd_data;
        end
        r_ret_cnt <= r_ret_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (req_valid && !flush) begin
            r_base_q    <= w_req_q;
            r_line_base <= {w_req_q, 2'b00};
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush) begin
            r_state <= S_ABORT;
          end else if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            if (r_issue_cnt == LAST_CNT) r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= S_ABORT;
          end else if (w_ret && (r_ret_cnt == LAST_CNT)) begin
            r_line_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || line_ack) begin
            r_line_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_ABORT: begin
          // Leave once only the tail (being dropped this cycle) can still be set.
          if ((r_vsr & ~VSR_TAIL) == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_iline_fill.sv
// Directed bench for ls_iline_fill with a fixed-latency local-store model returning address-tagged quadwords.
module tb_ls_iline_fill;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [15:0]  req_pc;
  logic         req_ready;
  logic         flush;
  logic         ls_grant;
  logic         ls_rd_en;
  logic [13:0]  ls_rd_addr;
  logic [127:0] ls_rd_data;
  logic         line_valid;
  logic [15:0]  line_base;
  logic [511:0] line_data;
  logic         line_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ls_iline_fill dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .flush(flush), .ls_grant(ls_grant),
    .ls_rd_en(ls_rd_en), .ls_rd_addr(ls_rd_addr), .ls_rd_data(ls_rd_data),
    .line_valid(line_valid), .line_base(line_base), .line_data(line_data),
    .line_ack(line_ack)
  );

  function automatic logic [127:0] qw(input logic [13:0] a);
    return {8{2'b10, a}};
  endfunction

  function automatic logic [511:0] line_of(input logic [13:0] b);
    return {qw(b), qw(b + 14'd1), qw(b + 14'd2), qw(b + 14'd3)};
  endfunction

  // Local store: data appears two cycles after the issue is sampled, junk otherwise.
  logic         m_v1 = 1'b0, m_v2 = 1'b0;
  logic [127:0] m_d1 = '0, m_d2 = '0;
  always @(posedge clk) begin
    m_v1 <= ls_rd_en;
    m_d1 <= qw(ls_rd_addr);
    m_v2 <= m_v1;
    m_d2 <= m_d1;
  end
  assign ls_rd_data = m_v2 ? m_d2 : {4{32'hDEADBEEF}};

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int pulses;
  logic exp_en;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0; ls_grant = 1'b0; line_ack = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_req_ready", 512'(req_ready), 512'(0));
    chk("rst_rd_en", 512'(ls_rd_en), 512'(0));
    chk("rst_rd_addr", 512'(ls_rd_addr), 512'(0));
    chk("rst_line_valid", 512'(line_valid), 512'(0));
    chk("rst_line_base", 512'(line_base), 512'(0));
    chk("rst_line_data", line_data, 512'(0));

    // Basic fill, continuous grant, ack withheld 20 cycles
    adv(); reset = 1'b0; req_valid = 1'b1; req_pc = 16'h0013; ls_grant = 1'b1;
    smp();
    chk("ready_after_reset", 512'(req_ready), 512'(1));
    adv(); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("a_rd_en", 512'(ls_rd_en), 512'(1));
      chk("a_rd_addr", 512'(ls_rd_addr), 512'(14'h0004 + 14'(i)));
      adv();
    end
    smp(); chk("a_lv_c5", 512'(line_valid), 512'(0));
    adv(); smp(); chk("a_lv_c6", 512'(line_valid), 512'(0));
    adv(); smp();
    chk("a_lv_c7", 512'(line_valid), 512'(1));
    chk("a_line_base", 512'(line_base), 512'(16'h0010));
    chk("a_line_data", line_data, line_of(14'h0004));
    for (int j = 0; j < 20; j++) begin
      adv(); smp();
      chk("a_hold_lv", 512'(line_valid), 512'(1));
      chk("a_hold_data", line_data, line_of(14'h0004));
      chk("a_hold_ready", 512'(req_ready), 512'(0));
    end
    adv(); line_ack = 1'b1; smp();
    chk("a_lv_at_ack", 512'(line_valid), 512'(1));
    adv(); line_ack = 1'b0; smp();
    chk("a_lv_after_ack", 512'(line_valid), 512'(0));
    chk("a_ready_after_ack", 512'(req_ready), 512'(1));

    // Grant toggling 1,0,1,0,...
    adv(); req_valid = 1'b1; req_pc = 16'h0107; ls_grant = 1'b0;
    smp(); chk("b_ready", 512'(req_ready), 512'(1));
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      adv(); req_valid = 1'b0; ls_grant = (c % 2 == 1);
      smp();
      exp_en = (c % 2 == 1) && (c <= 7);
      chk("b_rd_en", 512'(ls_rd_en), 512'(exp_en));
      if (exp_en) chk("b_rd_addr", 512'(ls_rd_addr), 512'(14'h0040 + 14'((c - 1) / 2)));
      if (ls_rd_en) pulses++;
      chk("b_line_valid", 512'(line_valid), 512'(c == 10));
    end
    chk("b_pulse_count", 512'(pulses), 512'(4));
    chk("b_line_base", 512'(line_base), 512'(16'h0100));
    chk("b_line_data", line_data, line_of(14'h0040));
    adv(); line_ack = 1'b1; smp();
    adv(); line_ack = 1'b0; smp();
    chk("b_lv_after_ack", 512'(line_valid), 512'(0));

    // Flush after second issue, then top-of-store line
    adv(); req_valid = 1'b1; req_pc = 16'h0200; ls_grant = 1'b1; smp();
    adv(); req_valid = 1'b0; smp();
    chk("c_rd_en_1", 512'(ls_rd_en), 512'(1));
    chk("c_rd_addr_1", 512'(ls_rd_addr), 512'(14'h0080));
    adv(); smp();
    chk("c_rd_en_2", 512'(ls_rd_en), 512'(1));
    chk("c_rd_addr_2", 512'(ls_rd_addr), 512'(14'h0081));
    adv(); flush = 1'b1; smp();
    chk("c_rd_en_flush", 512'(ls_rd_en), 512'(0));
    adv(); flush = 1'b0; smp();
    chk("c_rd_en_abort", 512'(ls_rd_en), 512'(0));
    chk("c_ready_abort", 512'(req_ready), 512'(0));
    chk("c_lv_abort", 512'(line_valid), 512'(0));
    adv(); req_valid = 1'b1; req_pc = 16'hFFF0; smp();
    chk("c_ready_idle", 512'(req_ready), 512'(1));
    chk("c_lv_idle", 512'(line_valid), 512'(0));
    adv(); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("c_top_rd_en", 512'(ls_rd_en), 512'(1));
      chk("c_top_rd_addr", 512'(ls_rd_addr), 512'(14'h3FFC + 14'(i)));
      adv();
    end
    smp(); chk("c_lv_c10", 512'(line_valid), 512'(0));
    adv(); smp(); chk("c_lv_c11", 512'(line_valid), 512'(0));
    adv(); smp();
    chk("c_lv_c12", 512'(line_valid), 512'(1));
    chk("c_line_base", 512'(line_base), 512'(16'hFFF0));
    chk("c_line_data", line_data, line_of(14'h3FFC));
    // Flush with a same-cycle ack in DONE
    adv(); flush = 1'b1; line_ack = 1'b1; smp();
    chk("c_lv_flush_done", 512'(line_valid), 512'(1));
    adv(); flush = 1'b0; line_ack = 1'b0; smp();
    chk("c_lv_after_flush", 512'(line_valid), 512'(0));
    chk("c_ready_after_flush", 512'(req_ready), 512'(1));

    // Flush beats a same-cycle request in IDLE
    adv(); flush = 1'b1; req_valid = 1'b1; req_pc = 16'h0013; smp();
    chk("d_ready_flush", 512'(req_ready), 512'(0));
    adv(); flush = 1'b0; req_valid = 1'b0; smp();
    chk("d_no_issue", 512'(ls_rd_en), 512'(0));
    chk("d_ready_after", 512'(req_ready), 512'(1));

    // Reset in WAIT with returns still in flight
    adv(); req_valid = 1'b1; req_pc = 16'h0040; smp();
    adv(); req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("e_rd_addr", 512'(ls_rd_addr), 512'(14'h0010 + 14'(i)));
      adv();
    end
    reset = 1'b1; smp();
    adv(); smp();
    chk("e_rst_ready", 512'(req_ready), 512'(0));
    chk("e_rst_rd_en", 512'(ls_rd_en), 512'(0));
    chk("e_rst_rd_addr", 512'(ls_rd_addr), 512'(0));
    chk("e_rst_lv", 512'(line_valid), 512'(0));
    chk("e_rst_base", 512'(line_base), 512'(0));
    chk("e_rst_data", line_data, 512'(0));
    adv(); reset = 1'b0; smp();
    chk("e_ready_after", 512'(req_ready), 512'(1));
    for (int k = 0; k < 6; k++) begin
      chk("e_late_lv", 512'(line_valid), 512'(0));
      chk("e_late_data", line_data, 512'(0));
      adv(); smp();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
